jtag_tap_sync: RTL and testbench
================================

# jtag_tap_sync

Synthesizable JTAG TAP slave sitting directly downstream of the simulation JTAG master. It consumes `tck_i`/`tms_i`/`tdi_i` from the master and returns `tdo_o`. All JTAG pins are oversampled in the system clock domain rather than using `tck` as a clock. The block runs the IEEE 1149.1 16-state TAP FSM and implements an instruction register with IDCODE, BYPASS and DEBUG instructions. It exposes single-cycle DR strobes to the debug unit when DEBUG is selected.

## Interface
- `IR_WIDTH`, 4, instruction register width.
- `IDCODE_VALUE`, 32'h149511C3, value captured in IDCODE DR.
- `IDCODE_OP`, 4'h2, IDCODE opcode.
- `DEBUG_OP`, 4'h8, DEBUG opcode. All-ones is BYPASS; any undefined opcode also selects BYPASS.
- `clk  in  1` system clock. Single clock domain. Must satisfy Tclk ≤ (TCK half period − 2 ns)/4.
- `rst_n  in  1` asynchronous, active-low reset.
- `tck_i`, `tms_i`, `tdi_i`  in  1 each; raw JTAG inputs, asynchronous to `clk`.
- `tdo_o  out  1` JTAG data out.
- `tlr_o  out  1` high while the FSM is in Test-Logic-Reset.
- `debug_select_o  out  1` IR == `DEBUG_OP`.
- `debug_tdi_o  out  1` synchronized tdi, valid with `shift_dr_o`.
- `debug_tdo_i  in  1` serial data from the debug unit.
- `capture_dr_o`, `shift_dr_o`, `update_dr_o`  out  1 each; one-`clk` strobes, gated by `debug_select_o`.

## Operation
- **Synchronizer.** 2-FF synchronizer on each of tck/tms/tdi. A third register on tck feeds edge detection. `tck_rise` and `tck_fall` are single-cycle pulses, never both in one cycle. tms and tdi use the same synchronizer depth so they stay aligned with tck.
- **FSM.** States: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR. The FSM advances only on `tck_rise`, using the synced tms and the standard 1149.1 transition table. Five consecutive tms=1 rises reach TLR from any state.
- **Rising-edge actions.** These are keyed on the state current at the rise, before the transition.
  - CapIR: IR shift register ← 4'b0101.
  - ShIR: IR shift register ← {tdi, sr[IR_WIDTH-1:1]}.
  - CapDR: the selected DR loads. IDCODE loads `IDCODE_VALUE`; BYPASS loads 0; DEBUG pulses `capture_dr_o`.
  - ShDR: the selected DR shifts tdi in at the MSB (bypass is 1 bit). DEBUG pulses `shift_dr_o`.
- **Falling-edge actions.**
  - UpdIR: IR ← IR shift register.
  - UpdDR with DEBUG: pulse `update_dr_o`.
  - `tdo_o` ← LSB of the active shift register (or `debug_tdo_i` under DEBUG) when the state is ShIR or ShDR; otherwise `tdo_o` ← 0.
- **TLR.** Entering TLR forces IR to the reset instruction: IDCODE, or BYPASS when IDCODE is compiled out.
- **Reset.** All outputs reset low except `tlr_o`=1. FSM=TLR; IR=reset instruction; shift registers=0. Asserting reset mid-scan aborts the scan immediately, with no update.

## Timing
- `tck_rise`/`tck_fall` assert 3 `clk` cycles after the tck pin edge.
- FSM state, strobes and shift registers update 1 cycle after the detected edge.
- `tdo_o` is valid 4 `clk` after tck falls. It is stable before the next tck rise given the clock constraint above.
- Strobes are exactly 1 `clk` wide, one per relevant tck edge.
- Capture and shift never coincide.
- `update_dr_o` fires once per UpdDR visit.

## Configuration
- **`JTAG_TAP_IDCODE_EN` defined.** The IDCODE DR and opcode are implemented, and the reset instruction is `IDCODE_OP`.
- **Undefined.** No 32-bit register is built. `IDCODE_OP` decodes as BYPASS, and the reset instruction is BYPASS.

## Test plan
- **Reset.** Hold `rst_n`=0 for 10 clk → `tdo_o`=0, `tlr_o`=1, `debug_select_o`=0, all strobes 0.
- **TLR exit.** Five tck cycles with tms=1, then one with tms=0 → `tlr_o` falls after the 6th rise (FSM in RTI).
- **IDCODE scan.** From RTI with the macro defined, scan 32 DR bits with tdi=0 → LSB-first tdo bits equal 0x149511C3. Without the macro → the first bit is 0, then the tdi bits are echoed.
- **IR capture and BYPASS.** Scan IR with 0xF → shifted-out IR bits are 1,0,1,0. Then an 8-bit DR scan of 0xA5 → captured tdo = 0x4A.
- **DEBUG scan.** IR scan 0x8 → `debug_select_o`=1. A 4-bit DR scan with `debug_tdo_i`=1 gives:
  - `capture_dr_o` ×1, `shift_dr_o` ×4, `update_dr_o` ×1;
  - tdo = 4'b1111;
  - `debug_tdi_o` matches tdi at each `shift_dr_o`.
- **Reset mid-scan.** Pulse `rst_n` low during the 10th bit of an IDCODE scan → `tlr_o`=1 and `tdo_o`=0 immediately. The next DR scan restarts from bit 0 of 0x149511C3.

Source files
------------

// File: rtl/jtag_tap_sync_if.sv
// JTAG pin bundle plus the debug-unit side-band of the TAP.
// The master modport drives the JTAG pins and debug_tdo_i; the slave is the TAP itself.
`timescale 1ns/1ps
interface jtag_tap_sync_if;
    logic tck_i;
    logic tms_i;
    logic tdi_i;
    logic tdo_o;
    logic tlr_o;
    logic debug_select_o;
    logic debug_tdi_o;
    logic debug_tdo_i;
    logic capture_dr_o;
    logic shift_dr_o;
    logic update_dr_o;

    modport master (
        output tck_i, tms_i, tdi_i, debug_tdo_i,
        input  tdo_o, tlr_o, debug_select_o, debug_tdi_o,
               capture_dr_o, shift_dr_o, update_dr_o
    );

    modport slave (
        input  tck_i, tms_i, tdi_i, debug_tdo_i,
        output tdo_o, tlr_o, debug_select_o, debug_tdi_o,
               capture_dr_o, shift_dr_o, update_dr_o
    );
endinterface

// File: rtl/jtag_tap_sync.sv
// JTAG TAP slave oversampling tck/tms/tdi in the clk domain. It supports IDCODE, BYPASS and DEBUG.
// Define JTAG_TAP_IDCODE_EN to build the IDCODE register; otherwise reset selects BYPASS.
`timescale 1ns/1ps
module jtag_tap_sync #(
    parameter int                  IR_WIDTH     = 4,
`ifdef JTAG_TAP_IDCODE_EN
    parameter logic [31:0]         IDCODE_VALUE = 32'h149511C3,
    parameter logic [IR_WIDTH-1:0] IDCODE_OP    = 4'h2,
`endif
    parameter logic [IR_WIDTH-1:0] DEBUG_OP     = 4'h8
) (
    input logic            clk,
    input logic            rst_n,
    jtag_tap_sync_if.slave bus
);

    typedef enum logic [3:0] {
        ST_TLR, ST_RTI, ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PAU_DR, ST_EX2_DR,
        ST_UPD_DR, ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PAU_IR, ST_EX2_IR, ST_UPD_IR
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(4'b0101);
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] RESET_IR = IDCODE_OP;
`else
    localparam logic [IR_WIDTH-1:0] RESET_IR = '1;
`endif

    logic tck_s1, tck_s2, tck_s3;
    logic tms_s1, tms_s2;
    logic tdi_s1, tdi_s2;
    logic tck_rise, tck_fall;

    tap_state_t          state, state_next;
    logic [IR_WIDTH-1:0] ir, ir_sr;
    logic                bypass_sr;
    logic                tdo_q, tlr_q, debug_tdi_q;
    logic                capture_q, shift_q, update_q;
    logic                is_debug;

    // tms/tdi share the tck depth so they are sampled on the same clk as the detected edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_s1 <= 1'b0;
            tck_s2 <= 1'b0;
            tck_s3 <= 1'b0;
            tms_s1 <= 1'b0;
            tms_s2 <= 1'b0;
            tdi_s1 <= 1'b0;
            tdi_s2 <= 1'b0;
        end else begin
            tck_s1 <= bus.tck_i;
            tck_s2 <= tck_s1;
            tck_s3 <= tck_s2;
            tms_s1 <= bus.tms_i;
            tms_s2 <= tms_s1;
            tdi_s1 <= bus.tdi_i;
            tdi_s2 <= tdi_s1;
        end
    end

    assign tck_rise = tck_s2 & ~tck_s3;
    assign tck_fall = ~tck_s2 & tck_s3;
    assign is_debug = (ir == DEBUG_OP);

    always_comb begin
        state_next = state;
        case (state)
            ST_TLR:    state_next = tms_s2 ? ST_TLR    : ST_RTI;
            ST_RTI:    state_next = tms_s2 ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: state_next = tms_s2 ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: state_next = tms_s2 ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  state_next = tms_s2 ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: state_next = tms_s2 ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: state_next = tms_s2 ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: state_next = tms_s2 ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: state_next = tms_s2 ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: state_next = tms_s2 ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: state_next = tms_s2 ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  state_next = tms_s2 ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: state_next = tms_s2 ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: state_next = tms_s2 ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: state_next = tms_s2 ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: state_next = tms_s2 ? ST_SEL_DR : ST_RTI;
            default:   state_next = ST_TLR;
        endcase
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] idcode_sr;
    logic        is_idcode;

    assign is_idcode = (ir == IDCODE_OP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idcode_sr <= '0;
        end else if (tck_rise && is_idcode) begin
            if (state == ST_CAP_DR) begin
                idcode_sr <= IDCODE_VALUE;
            end else if (state == ST_SH_DR) begin
                idcode_sr <= {tdi_s2, idcode_sr[31:1]};
            end
        end
    end
`endif

    // Rise actions key on the pre-transition state; rise and fall never share a cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_TLR;
            ir          <= RESET_IR;
            ir_sr       <= '0;
            bypass_sr   <= 1'b0;
            tdo_q       <= 1'b0;
            tlr_q       <= 1'b1;
            debug_tdi_q <= 1'b0;
            capture_q   <= 1'b0;
            shift_q     <= 1'b0;
            update_q    <= 1'b0;
        end else begin
            capture_q   <= 1'b0;
            shift_q     <= 1'b0;
            update_q    <= 1'b0;
            debug_tdi_q <= tdi_s2;
            if (tck_rise) begin
                state <= state_next;
                tlr_q <= (state_next == ST_TLR);
                if (state_next == ST_TLR) begin
                    ir <= RESET_IR;
                end
                case (state)
                    ST_CAP_IR: ir_sr <= IR_CAPTURE;
                    ST_SH_IR:  ir_sr <= {tdi_s2, ir_sr[IR_WIDTH-1:1]};
                    ST_CAP_DR: begin
                        bypass_sr <= 1'b0;
                        capture_q <= is_debug;
                    end
                    ST_SH_DR: begin
                        bypass_sr <= tdi_s2;
                        shift_q   <= is_debug;
                    end
                    default: ;
                endcase
            end
            if (tck_fall) begin
                if (state == ST_UPD_IR) begin
                    ir <= ir_sr;
                end
                update_q <= (state == ST_UPD_DR) && is_debug;
                if (state == ST_SH_IR) begin
                    tdo_q <= ir_sr[0];
                end else if (state == ST_SH_DR) begin
                    if (is_debug) begin
                        tdo_q <= bus.debug_tdo_i;
`ifdef JTAG_TAP_IDCODE_EN
                    end else if (is_idcode) begin
                        tdo_q <= idcode_sr[0];
`endif
                    end else begin
                        tdo_q <= bypass_sr;
                    end
                end else begin
                    tdo_q <= 1'b0;
                end
            end
        end
    end

    assign bus.tdo_o          = tdo_q;
    assign bus.tlr_o          = tlr_q;
    assign bus.debug_select_o = is_debug;
    assign bus.debug_tdi_o    = debug_tdi_q;
    assign bus.capture_dr_o   = capture_q;
    assign bus.shift_dr_o     = shift_q;
    assign bus.update_dr_o    = update_q;

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Directed bench for jtag_tap_sync: bit-banged TAP scans with hand-computed expectations.
// Expectations follow JTAG_TAP_IDCODE_EN so the bench matches either build.
`timescale 1ns/1ps
module tb_jtag_tap_sync;

    localparam int HALF = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec_count = 0;
    int   miss_count = 0;

    int cap_cnt = 0;
    int shift_cnt = 0;
    int upd_cnt = 0;
    int tdi_err = 0;
    int overlap_cnt = 0;

    jtag_tap_sync_if bus();

    jtag_tap_sync dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Strobes are one clk wide, so each is seen exactly once on the falling clk edge
    always @(negedge clk) begin
        if (bus.capture_dr_o) cap_cnt++;
        if (bus.update_dr_o) upd_cnt++;
        if (bus.shift_dr_o) begin
            shift_cnt++;
            if (bus.debug_tdi_o !== bus.tdi_i) tdi_err++;
        end
        if (bus.capture_dr_o && bus.shift_dr_o) overlap_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One tck period; tdo is sampled just before the rise, long after the previous fall
    task automatic applyStimulus(input logic tms_v, input logic tdi_v, output logic tdo_v);
        bus.tms_i = tms_v;
        bus.tdi_i = tdi_v;
        #HALF;
        tdo_v = bus.tdo_o;
        bus.tck_i = 1'b1;
        #HALF;
        bus.tck_i = 1'b0;
    endtask

    task automatic dr_scan(input int len, input logic [31:0] tdi_bits,
                           output logic [31:0] tdo_bits);
        logic b;
        tdo_bits = '0;
        applyStimulus(1'b1, 1'b0, b);
        applyStimulus(1'b0, 1'b0, b);
        applyStimulus(1'b0, 1'b0, b);
        for (int i = 0; i < len; i++) begin
            applyStimulus(i == len - 1, tdi_bits[i], b);
            tdo_bits[i] = b;
        end
        applyStimulus(1'b1, 1'b0, b);
        applyStimulus(1'b0, 1'b0, b);
    endtask

    task automatic ir_scan(input logic [3:0] ir_bits, output logic [3:0] tdo_bits);
        logic b;
        tdo_bits = '0;
        applyStimulus(1'b1, 1'b0, b);
        applyStimulus(1'b1, 1'b0, b);
        applyStimulus(1'b0, 1'b0, b);
        applyStimulus(1'b0, 1'b0, b);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 3, ir_bits[i], b);
            tdo_bits[i] = b;
        end
        applyStimulus(1'b1, 1'b0, b);
        applyStimulus(1'b0, 1'b0, b);
    endtask

    initial begin
        logic        b;
        logic [3:0]  ir_out;
        logic [31:0] dr_out;
        logic [31:0] pattern;
        logic [31:0] exp_idcode;
        int          cap0, shift0, upd0, err0, ovl0;

        bus.tck_i       = 1'b0;
        bus.tms_i       = 1'b1;
        bus.tdi_i       = 1'b0;
        bus.debug_tdo_i = 1'b0;

        #HALF;
        checkOutput("rst_tdo", 32'(bus.tdo_o), 32'd0);
        checkOutput("rst_tlr", 32'(bus.tlr_o), 32'd1);
        checkOutput("rst_debug_select", 32'(bus.debug_select_o), 32'd0);
        checkOutput("rst_capture", 32'(bus.capture_dr_o), 32'd0);
        checkOutput("rst_shift", 32'(bus.shift_dr_o), 32'd0);
        checkOutput("rst_update", 32'(bus.update_dr_o), 32'd0);
        rst_n = 1'b1;
        #HALF;

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, b);
        checkOutput("tlr_hold", 32'(bus.tlr_o), 32'd1);
        applyStimulus(1'b0, 1'b0, b);
        checkOutput("tlr_exit", 32'(bus.tlr_o), 32'd0);

        pattern = 32'hDEADBEEF;
        dr_scan(32, pattern, dr_out);
`ifdef JTAG_TAP_IDCODE_EN
        checkOutput("idcode_scan", dr_out, 32'h149511C3);
`else
        checkOutput("idcode_scan", dr_out, pattern << 1);
`endif

        cap0 = cap_cnt;
        shift0 = shift_cnt;
        ir_scan(4'hF, ir_out);
        checkOutput("ir_capture", 32'(ir_out), 32'h5);
        checkOutput("bypass_select", 32'(bus.debug_select_o), 32'd0);
        dr_scan(8, 32'hA5, dr_out);
        checkOutput("bypass_scan", dr_out, 32'h4A);
        checkOutput("bypass_no_strobes", 32'(cap_cnt - cap0 + shift_cnt - shift0), 32'd0);

        ir_scan(4'h8, ir_out);
        checkOutput("ir_capture_dbg", 32'(ir_out), 32'h5);
        checkOutput("debug_select", 32'(bus.debug_select_o), 32'd1);
        bus.debug_tdo_i = 1'b1;
        cap0 = cap_cnt;
        shift0 = shift_cnt;
        upd0 = upd_cnt;
        err0 = tdi_err;
        ovl0 = overlap_cnt;
        dr_scan(4, 32'h6, dr_out);
        checkOutput("debug_tdo", dr_out, 32'hF);
        checkOutput("debug_capture_cnt", 32'(cap_cnt - cap0), 32'd1);
        checkOutput("debug_shift_cnt", 32'(shift_cnt - shift0), 32'd4);
        checkOutput("debug_update_cnt", 32'(upd_cnt - upd0), 32'd1);
        checkOutput("debug_tdi_err", 32'(tdi_err - err0), 32'd0);
        checkOutput("debug_overlap", 32'(overlap_cnt - ovl0), 32'd0);
        bus.debug_tdo_i = 1'b0;

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, b);
        checkOutput("tlr_return", 32'(bus.tlr_o), 32'd1);
        checkOutput("tlr_ir_reset", 32'(bus.debug_select_o), 32'd0);
        applyStimulus(1'b0, 1'b0, b);

        applyStimulus(1'b1, 1'b0, b);
        applyStimulus(1'b0, 1'b0, b);
        applyStimulus(1'b0, 1'b0, b);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, b);
        bus.tdi_i = 1'b1;
        #50;
        rst_n = 1'b0;
        #1;
        checkOutput("midscan_tlr", 32'(bus.tlr_o), 32'd1);
        checkOutput("midscan_tdo", 32'(bus.tdo_o), 32'd0);
        #19;
        rst_n = 1'b1;
        #30;
        applyStimulus(1'b0, 1'b0, b);
        checkOutput("midscan_rti", 32'(bus.tlr_o), 32'd0);
        dr_scan(32, 32'h0, dr_out);
`ifdef JTAG_TAP_IDCODE_EN
        exp_idcode = 32'h149511C3;
`else
        exp_idcode = 32'h0;
`endif
        checkOutput("midscan_restart", dr_out, exp_idcode);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
